mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the fetch stage (IF) and the
//  load/store stage (DM) of the RISC-V core. Arbitrates, sequences each memory transaction
//  over a req/ack handshake and drives the pipeline stall flag consumed by control_logic.
//  DM has priority; a starvation counter forces an IF grant after MAX_WAIT consecutive losses.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  MAX_WAIT  4   consecutive DM wins (with IF pending) before IF is forced; >=1
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  if_req_i     in   1       fetch request, held with stable if_addr_i until if_valid_o
//  if_addr_i    in   ADDR_W  fetch address (PC)
//  if_valid_o   out  1       1-cycle pulse: if_rdata_o holds fetched instruction
//  if_rdata_o   out  DATA_W  fetched instruction
//  dm_req_i     in   1       data request, held with stable addr/we/wdata until dm_valid_o
//  dm_we_i      in   1       1 = store, 0 = load (mem_rw from control_logic)
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_valid_o   out  1       1-cycle pulse: access done; dm_rdata_o valid for loads
//  dm_rdata_o   out  DATA_W  load data
//  mem_req_o    out  1       memory request, held until mem_ack_i
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_ack_i    in   1       memory done (any latency >= 1 cycle after mem_req_o rises)
//  mem_rdata_i  in   DATA_W  memory read data, valid in the mem_ack_i cycle
//  stall_o      out  1       (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o), combinational
// BEHAVIOUR
//  Reset: state=IDLE, owner=IF, wait_cnt=0; all registered outputs 0 (mem_req/we/addr/wdata,
//   if/dm_valid, if/dm_rdata). Async: mem_req_o drops immediately; in-flight access abandoned.
//  FSM, all outputs registered except stall_o:
//   IDLE: no req -> IDLE. Any req -> pick winner, latch its addr/we/wdata into mem_*,
//     mem_req_o<=1, owner<=winner, -> BUSY. IF requests always have mem_we_o=0.
//     Winner: DM if dm_req_i and wait_cnt<MAX_WAIT; IF if IF is the only requester or
//     wait_cnt==MAX_WAIT (IF forced even with DM pending).
//   BUSY: mem_* held stable. mem_ack_i=1 -> mem_req_o<=0, mem_we_o<=0,
//     <owner>_rdata_o<=mem_rdata_i, <owner>_valid_o<=1, -> RESP. Otherwise stay.
//   RESP: valid pulse visible this cycle only; requests NOT sampled; -> IDLE.
//  Requester rule: deassert req, or present the next request, in the cycle after valid.
//  Min transaction: 3 cycles (grant edge, ack cycle, RESP) with 1-cycle memory ack.
//  rdata_o of the non-owner never changes; rdata_o holds its value after the valid pulse.
//  wait_cnt: +1 (saturating at MAX_WAIT) when DM wins with if_req_i high;
//   cleared to 0 when IF wins; unchanged otherwise. Width $clog2(MAX_WAIT+1).
//  Boundaries: mem_ack_i outside BUSY ignored. A req dropped during BUSY still completes;
//   valid still pulses. Simultaneous IF+DM in IDLE uses the winner rule above. Reset in
//   BUSY/RESP: outputs cleared that instant; after release, IDLE re-arbitrates live reqs.
// TESTING
//  1 IF only, addr 0x0000_0010, ack 1 cycle after req, rdata 0x0031_0233 -> mem_req 1 cycle,
//    mem_we=0; if_valid pulses 1 cycle with if_rdata=0x0031_0233; stall_o high until then.
//  2 DM store, addr 0x0000_0100, wdata 0xDEAD_BEEF, ack after 3 cycles -> mem_we=1 and
//    mem_addr/wdata stable 3 cycles; dm_valid one pulse; if_valid stays 0.
//  3 IF+DM in same IDLE cycle -> DM served first, then IF; wait_cnt 0->1->0.
//  4 IF held high, DM re-requests after each dm_valid, MAX_WAIT=4 -> DM wins 4 times,
//    5th grant goes to IF despite DM pending; wait_cnt back to 0.
//  5 rst pulsed in BUSY, then ack -> mem_req_o drops at rst; ack ignored; no valid pulse;
//    with if_req_i high after rst release, new IF grant within 1 cycle.
//  6 Spurious mem_ack_i in IDLE; load with ack at once -> ignored; load returns
//    0x0000_00FF on dm_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch (IF) and
//            load/store (DM). DM has priority, with anti-starvation for IF.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_valid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    localparam int                 c_CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_WAIT = c_CNT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [c_CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_valid_q,  if_valid_d;
    logic                dm_valid_q,  dm_valid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                w_dm_wins;

    // DM wins unless IF is also waiting and has already lost MAX_WAIT times in a row
    assign w_dm_wins = dm_req_i && (!if_req_i || (wait_cnt_q < c_MAX_WAIT));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    mem_req_d = 1'b1;
                    state_d   = S_BUSY;
                    if (w_dm_wins) begin
                        owner_d     = OWN_DM;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        if (if_req_i && (wait_cnt_q != c_MAX_WAIT)) begin
                            wait_cnt_d = wait_cnt_q + c_CNT_ONE;
                        end
                    end else begin
                        owner_d    = OWN_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr_i;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_RESP;
                    if (owner_q == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = mem_rdata_i;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_valid_o  = if_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_valid_o  = dm_valid_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_o     = (if_req_i && !if_valid_q) || (dm_req_i && !dm_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and random checks of mem_port_arbiter against a
//            transaction-level model with a sparse memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    wire         if_valid_o, dm_valid_o, mem_req_o, mem_we_o, stall_o;
    wire  [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] mem [logic [31:0]];

    // Transaction model: port phase 0 free, 1 access outstanding, 2 response cycle
    int          phase = 0;
    bit          own_dm;
    int          streak = 0;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
    int          busy_cnt, ack_lat = 1, req_cycles;
    bit          spur = 1'b0;
    bit          e_ifv, e_dmv;
    logic [31:0] e_if_rd = '0, e_dm_rd = '0;
    bit          grants[$];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ({a[15:0], 16'hC0DE} ^ 32'h1357_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          s_if, s_dm, s_ack, dmw;
        logic [31:0] s_rd;
        s_if = if_req; s_dm = dm_req; s_ack = mem_ack; s_rd = mem_rdata;
        e_ifv = 1'b0; e_dmv = 1'b0;
        case (phase)
            0: if (s_if || s_dm) begin
                dmw = s_dm && !(s_if && streak >= MW);
                grants.push_back(dmw);
                own_dm = dmw; phase = 1; busy_cnt = 0;
                if (dmw) begin
                    g_addr = dm_addr; g_we = dm_we; g_wdata = dm_wdata;
                    if (s_if) streak++;
                end else begin
                    g_addr = if_addr; g_we = 1'b0; streak = 0;
                end
            end
            1: if (s_ack) begin
                phase = 2;
                if (own_dm) begin e_dmv = 1'b1; e_dm_rd = s_rd; end
                else        begin e_ifv = 1'b1; e_if_rd = s_rd; end
            end
            default: phase = 0;
        endcase
        @(negedge clk);
        chk("mem_req", mem_req_o, phase == 1);
        if (phase == 1) begin
            req_cycles++;
            chk("mem_addr", mem_addr_o, g_addr);
            chk("mem_we", mem_we_o, g_we);
            if (g_we) chk("mem_wdata", mem_wdata_o, g_wdata);
        end else begin
            chk("mem_we_idle", mem_we_o, 1'b0);
        end
        chk("if_valid", if_valid_o, e_ifv);
        chk("dm_valid", dm_valid_o, e_dmv);
        chk("if_rdata", if_rdata_o, e_if_rd);
        chk("dm_rdata", dm_rdata_o, e_dm_rd);
        chk("stall", stall_o, (if_req && !e_ifv) || (dm_req && !e_dmv));
        if (e_ifv) if_req = 1'b0;
        if (e_dmv) dm_req = 1'b0;
        if (phase == 1) begin
            busy_cnt++;
            if (busy_cnt >= ack_lat || spur) begin
                mem_ack = 1'b1;
                mem_rdata = rd(g_addr);
                if (g_we) mem[g_addr] = g_wdata;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
        end else begin
            mem_ack = spur; mem_rdata = $urandom;
        end
    endtask

    task automatic wait_valid(input bit dm, input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            step();
            if (dm ? e_dmv : e_ifv) break;
        end
        chk(tag, k < 40, 1'b1);
    endtask

    initial begin
        int n0;
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        @(negedge clk);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_valids", {if_valid_o, dm_valid_o, stall_o}, 3'b000);
        chk("rst_rdata", if_rdata_o | dm_rdata_o, 32'h0);
        rst = 1'b0;

        // 1: single fetch, one-cycle memory
        mem[32'h10] = 32'h0031_0233; ack_lat = 1; req_cycles = 0;
        if_req = 1'b1; if_addr = 32'h10;
        wait_valid(1'b0, "t1_timeout");
        chk("t1_rdata", if_rdata_o, 32'h0031_0233);
        chk("t1_req_cycles", req_cycles, 1);

        // 2: store with three-cycle memory
        ack_lat = 3; req_cycles = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        wait_valid(1'b1, "t2_timeout");
        chk("t2_req_cycles", req_cycles, 3);
        chk("t2_if_rdata_kept", if_rdata_o, 32'h0031_0233);

        // 3: simultaneous requests
        ack_lat = 1; n0 = grants.size();
        if_req = 1'b1; if_addr = 32'h14;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        wait_valid(1'b0, "t3_timeout");
        chk("t3_count", grants.size() - n0, 2);
        chk("t3_first_dm", grants[n0], 1'b1);
        chk("t3_then_if", grants[n0+1], 1'b0);

        // 4: DM streaming while IF waits
        n0 = grants.size();
        if_req = 1'b1; if_addr = 32'h18;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int k = 0; k < 60; k++) begin
            step();
            if (e_dmv) begin dm_req = 1'b1; dm_addr = {26'd0, 4'($urandom), 2'b00}; end
            if (e_ifv) break;
        end
        chk("t4_count", grants.size() - n0, 5);
        for (int i = 0; i < 5; i++) chk("t4_grant", grants[n0+i], i < 4);
        wait_valid(1'b1, "t4_drain");

        // 5: reset during an outstanding access
        ack_lat = 10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        step(); step();
        #2 rst = 1'b1;
        #1 chk("t5_req_drop", mem_req_o, 1'b0);
        phase = 0; streak = 0; e_if_rd = '0; e_dm_rd = '0;
        dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        if_req = 1'b1; if_addr = 32'h1C;
        @(negedge clk);
        chk("t5_no_valid", {if_valid_o, dm_valid_o, mem_req_o}, 3'b000);
        chk("t5_rdata_clr", dm_rdata_o, 32'h0);
        rst = 1'b0; ack_lat = 1; req_cycles = 0;
        step();
        chk("t5_if_grant", req_cycles, 1);
        wait_valid(1'b0, "t5_timeout");

        // 6: spurious ack while idle, then a load
        spur = 1'b1; mem_ack = 1'b1;
        step(); step();
        mem[32'h200] = 32'h0000_00FF;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        wait_valid(1'b1, "t6_timeout");
        chk("t6_rdata", dm_rdata_o, 32'h0000_00FF);
        spur = 1'b0;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if (phase == 0) ack_lat = $urandom_range(1, 4);
            if (!if_req && ($urandom_range(0, 2) == 0)) begin
                if_req = 1'b1; if_addr = {26'd0, 4'($urandom), 2'b00};
            end
            if (!dm_req && ($urandom_range(0, 2) == 0)) begin
                dm_req = 1'b1; dm_we = 1'($urandom);
                dm_addr = {26'd0, 4'($urandom), 2'b00}; dm_wdata = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
